sprite_move_ctrl: RTL and testbench
===================================

Name: sprite_move_ctrl

Overview:
- Motion controller for the single on-screen square of the VGA animation top level.
- Synchronises and debounces the four raw direction buttons and resolves conflicting presses.
- Sequences position updates once per frame tick, with hold-to-accelerate and screen-edge clamping.
- Drives the square bounding box (x1, x2, y1, y2) consumed by the pixel-compare logic in the top level.

Parameters:
- IX, 160, initial/reset centre x
- IY, 120, initial/reset centre y
- H_SIZE, 60, half side length of the square
- D_WIDTH, 640, display width in pixels
- D_HEIGHT, 480, display height in pixels
- STEP, 1, pixels moved per frame tick in SLOW state
- FAST_STEP, 4, pixels moved per frame tick in FAST state
- HOLD_FRAMES, 30, number of slow steps taken before switching to FAST (must be ≥1)
- DB_CYCLES, 1000000, consecutive i_clk cycles a changed input must be stable before it is accepted (10 ms at 100 MHz)

Ports:
- i_clk  in  1  system clock, 100 MHz
- i_rst  in  1  synchronous reset, active-high
- i_ani_stb  in  1  pixel strobe, 25 MHz enable
- i_animate  in  1  end-of-frame pulse from the VGA timing generator
- i_left  in  1  raw button input, asynchronous
- i_right  in  1  raw button input, asynchronous
- i_top  in  1  raw button input, asynchronous
- i_bottom  in  1  raw button input, asynchronous
- o_x1  out  12  left edge, equal to x − H_SIZE
- o_x2  out  12  right edge, equal to x + H_SIZE
- o_y1  out  12  top edge, equal to y − H_SIZE
- o_y2  out  12  bottom edge, equal to y + H_SIZE
- o_moving  out  1  high when state is SLOW or FAST
- o_fast  out  1  high when state is FAST

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge):
  - x=IX, y=IY, state=IDLE, hold counter=0.
  - All synchroniser flops, debounced levels and debounce counters cleared to 0.
  - Resulting outputs: o_x1=IX−H_SIZE, o_x2=IX+H_SIZE, o_y1=IY−H_SIZE, o_y2=IY+H_SIZE, o_moving=0, o_fast=0.
  - Reset asserted mid-motion takes effect on that edge and overrides any simultaneous frame tick.
- Synchronisation: each button passes through a 2-flop synchroniser.
- Debounce (per button):
  - The counter increments while the synchronised level differs from the debounced level.
  - When the counter reaches DB_CYCLES−1, the debounced level toggles and the counter clears.
  - Any cycle where the synchronised and debounced levels match clears the counter.
  - Total latency from raw edge to debounced edge: 2+DB_CYCLES clocks.
- Direction resolution (from debounced levels only):
  - dx = +1 if right & ~left; −1 if left & ~right; 0 if neither or both pressed.
  - dy = +1 if bottom & ~top; −1 if top & ~bottom; 0 if neither or both pressed.
  - dir = (dx, dy). dir is zero when both dx and dy are 0.
- Frame tick = i_animate & i_ani_stb. State and position change only on a frame tick; between ticks everything holds.
- State machine, evaluated on each frame tick:
  - IDLE: dir zero → stay IDLE. Otherwise move STEP along dir, latch dir into prev_dir, cnt=1, go to SLOW; if HOLD_FRAMES==1, go to FAST instead.
  - SLOW:
    - dir zero → IDLE, cnt=0, no move.
    - dir ≠ prev_dir → move STEP, prev_dir=dir, cnt=1, stay SLOW.
    - Otherwise → move STEP, cnt=cnt+1; if the new cnt==HOLD_FRAMES, go to FAST.
  - FAST:
    - dir zero → IDLE, cnt=0.
    - dir ≠ prev_dir → move STEP, prev_dir=dir, cnt=1, go to SLOW.
    - Otherwise → move FAST_STEP, stay FAST.
- Arithmetic and clamping:
  - Computed in 13-bit signed: nx = x + dx·step.
  - Clamp nx to [H_SIZE, D_WIDTH−H_SIZE]; clamp ny to [H_SIZE, D_HEIGHT−H_SIZE].
  - The square never leaves the screen and never wraps.
  - A clamped axis does not change state; state depends on dir only.
  - Diagonal motion moves both axes by the full step.
- Outputs: o_x1/o_x2/o_y1/o_y2 are registered, updating one clock after the tick edge that changes x/y. o_moving and o_fast decode directly from state.

Test Plan (DB_CYCLES=4, HOLD_FRAMES=3, STEP=1, FAST_STEP=4, defaults otherwise):
- Reset release → o_x1=100, o_x2=220, o_y1=60, o_y2=180, o_moving=0.
- Hold i_right, then 5 frame ticks → x steps +1,+1,+1,+4,+4 (x=171); o_fast=1 after the 3rd tick; release right → o_moving=0 on the next tick, x stays 171.
- i_right glitch of 3 clocks → debounced level unchanged; 10 ticks later x still 160.
- Left and right held together, plus top → x stays 160, y decreases by 1 per tick; after 3 ticks o_fast=1.
- Hold i_left for 50 ticks from x=160 → x clamps at 60, o_x1=0; o_fast stays 1 while held.
- In FAST, switch from right to bottom without a zero gap → next tick moves y +1 (SLOW, cnt=1); assert i_rst coincident with a tick → x=160, y=120, state IDLE.

Source files
------------

// File: rtl/sprite_move_ctrl.sv
// Motion controller for the on-screen square: button sync/debounce, per-frame
// stepping with hold-to-accelerate, edge clamping and bounding-box outputs.
module sprite_move_ctrl #(
   parameter int IX          = 160,
   parameter int IY          = 120,
   parameter int H_SIZE      = 60,
   parameter int D_WIDTH     = 640,
   parameter int D_HEIGHT    = 480,
   parameter int STEP        = 1,
   parameter int FAST_STEP   = 4,
   parameter int HOLD_FRAMES = 30,
   parameter int DB_CYCLES   = 1000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ani_stb,
   input  logic        i_animate,
   input  logic        i_left,
   input  logic        i_right,
   input  logic        i_top,
   input  logic        i_bottom,
   output logic [11:0] o_x1,
   output logic [11:0] o_x2,
   output logic [11:0] o_y1,
   output logic [11:0] o_y2,
   output logic        o_moving,
   output logic        o_fast
);

   localparam int CW_DB   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int CW_HOLD = $clog2(HOLD_FRAMES + 1);
   localparam logic [CW_DB-1:0]   DB_LAST  = CW_DB'(DB_CYCLES - 1);
   localparam logic [CW_HOLD-1:0] HOLD_CNT = CW_HOLD'(HOLD_FRAMES);
   localparam logic signed [12:0] X_MIN = 13'(H_SIZE);
   localparam logic signed [12:0] X_MAX = 13'(D_WIDTH - H_SIZE);
   localparam logic signed [12:0] Y_MIN = 13'(H_SIZE);
   localparam logic signed [12:0] Y_MAX = 13'(D_HEIGHT - H_SIZE);

   typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

   // Bit order: 0=left, 1=right, 2=top, 3=bottom
   logic [3:0] raw_btn;
   logic [3:0] deb_btn;

   assign raw_btn = {i_bottom, i_top, i_right, i_left};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         logic             s1_reg;
         logic             s2_reg;
         logic             lvl_reg;
         logic [CW_DB-1:0] cnt_reg;

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               s1_reg  <= 1'b0;
               s2_reg  <= 1'b0;
               lvl_reg <= 1'b0;
               cnt_reg <= '0;
            end else begin
               s1_reg <= raw_btn[gi];
               s2_reg <= s1_reg;
               // A change is accepted only after DB_CYCLES stable cycles
               if (s2_reg != lvl_reg) begin
                  if (cnt_reg == DB_LAST) begin
                     lvl_reg <= s2_reg;
                     cnt_reg <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign deb_btn[gi] = lvl_reg;
      end
   endgenerate

   function automatic logic [11:0] clamp_pos(input logic signed [12:0] v,
                                             input logic signed [12:0] lo,
                                             input logic signed [12:0] hi);
      logic signed [12:0] r;
      r = v;
      if (v < lo)
         r = lo;
      else if (v > hi)
         r = hi;
      return r[11:0];
   endfunction

   logic signed [1:0]   dx, dy;
   logic                dir_zero, dir_same, tick;
   state_t              state_reg, state_next;
   logic [11:0]         x_reg, x_next, y_reg, y_next;
   logic signed [1:0]   pdx_reg, pdx_next, pdy_reg, pdy_next;
   logic [CW_HOLD-1:0]  cnt_reg, cnt_next, cnt_inc;
   logic                move, use_fast;
   logic signed [12:0]  step_s, x_s, y_s, nx_raw, ny_raw;

   always_comb begin
      dx = 2'sd0;
      dy = 2'sd0;
      if (deb_btn[1] && !deb_btn[0])
         dx = 2'sd1;
      else if (deb_btn[0] && !deb_btn[1])
         dx = -2'sd1;
      if (deb_btn[3] && !deb_btn[2])
         dy = 2'sd1;
      else if (deb_btn[2] && !deb_btn[3])
         dy = -2'sd1;
   end

   assign dir_zero = (dx == 2'sd0) && (dy == 2'sd0);
   assign dir_same = (dx == pdx_reg) && (dy == pdy_reg);
   assign tick     = i_animate & i_ani_stb;
   assign cnt_inc  = cnt_reg + 1'b1;

   always_comb begin
      state_next = state_reg;
      pdx_next   = pdx_reg;
      pdy_next   = pdy_reg;
      cnt_next   = cnt_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      move       = 1'b0;
      use_fast   = 1'b0;
      if (tick) begin
         case (state_reg)
            IDLE: begin
               if (!dir_zero) begin
                  move       = 1'b1;
                  pdx_next   = dx;
                  pdy_next   = dy;
                  cnt_next   = CW_HOLD'(1);
                  state_next = (HOLD_FRAMES == 1) ? FAST : SLOW;
               end
            end
            SLOW: begin
               if (dir_zero) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (!dir_same) begin
                  move     = 1'b1;
                  pdx_next = dx;
                  pdy_next = dy;
                  cnt_next = CW_HOLD'(1);
               end else begin
                  move     = 1'b1;
                  cnt_next = cnt_inc;
                  if (cnt_inc == HOLD_CNT)
                     state_next = FAST;
               end
            end
            FAST: begin
               if (dir_zero) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (!dir_same) begin
                  move       = 1'b1;
                  pdx_next   = dx;
                  pdy_next   = dy;
                  cnt_next   = CW_HOLD'(1);
                  state_next = SLOW;
               end else begin
                  move     = 1'b1;
                  use_fast = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end

      step_s = use_fast ? 13'(FAST_STEP) : 13'(STEP);
      x_s    = $signed({1'b0, x_reg});
      y_s    = $signed({1'b0, y_reg});
      case (dx)
         2'sd1:   nx_raw = x_s + step_s;
         -2'sd1:  nx_raw = x_s - step_s;
         default: nx_raw = x_s;
      endcase
      case (dy)
         2'sd1:   ny_raw = y_s + step_s;
         -2'sd1:  ny_raw = y_s - step_s;
         default: ny_raw = y_s;
      endcase
      if (move) begin
         x_next = clamp_pos(nx_raw, X_MIN, X_MAX);
         y_next = clamp_pos(ny_raw, Y_MIN, Y_MAX);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
         x_reg     <= 12'(IX);
         y_reg     <= 12'(IY);
         pdx_reg   <= 2'sd0;
         pdy_reg   <= 2'sd0;
         cnt_reg   <= '0;
         o_x1      <= 12'(IX - H_SIZE);
         o_x2      <= 12'(IX + H_SIZE);
         o_y1      <= 12'(IY - H_SIZE);
         o_y2      <= 12'(IY + H_SIZE);
      end else begin
         state_reg <= state_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         pdx_reg   <= pdx_next;
         pdy_reg   <= pdy_next;
         cnt_reg   <= cnt_next;
         o_x1      <= x_reg - 12'(H_SIZE);
         o_x2      <= x_reg + 12'(H_SIZE);
         o_y1      <= y_reg - 12'(H_SIZE);
         o_y2      <= y_reg + 12'(H_SIZE);
      end
   end

   assign o_moving = (state_reg != IDLE);
   assign o_fast   = (state_reg == FAST);

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Randomised self-checking bench for sprite_move_ctrl against a run-length
// model of the motion rules (steady buttons, per-tick position/state checks).
module tb_sprite_move_ctrl;

   localparam int IX = 160, IY = 120, H = 60, DW = 640, DH = 480;
   localparam int STEP = 1, FSTEP = 4, HOLD = 3, DB = 4;

   logic clk = 1'b0, rst = 1'b1, stb = 1'b0, anim = 1'b0;
   logic bl = 1'b0, br = 1'b0, bt = 1'b0, bb = 1'b0;
   logic [11:0] x1, x2, y1, y2;
   logic moving, fast;

   int pass_cnt = 0, check_cnt = 0, tick_no = 0;
   // Model: accepted button levels, position, and length of the current
   // run of consecutive ticks with one unchanged non-zero direction.
   int m_l, m_r, m_t, m_b, m_x, m_y, m_run, m_pdx, m_pdy;

   sprite_move_ctrl #(
      .IX(IX), .IY(IY), .H_SIZE(H), .D_WIDTH(DW), .D_HEIGHT(DH),
      .STEP(STEP), .FAST_STEP(FSTEP), .HOLD_FRAMES(HOLD), .DB_CYCLES(DB)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(anim),
      .i_left(bl), .i_right(br), .i_top(bt), .i_bottom(bb),
      .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2),
      .o_moving(moving), .o_fast(fast)
   );

   always #5 clk = ~clk;

   function automatic int axis(int pos, int neg);
      if (pos != 0 && neg == 0) return 1;
      if (neg != 0 && pos == 0) return -1;
      return 0;
   endfunction

   function automatic int clampi(int v, int lo, int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic logic [49:0] exp_vec();
      return {12'(m_x - H), 12'(m_x + H), 12'(m_y - H), 12'(m_y + H),
              1'(m_run > 0), 1'(m_run >= HOLD)};
   endfunction

   function automatic string fmt(logic [49:0] v);
      return $sformatf("x1=%0d x2=%0d y1=%0d y2=%0d moving=%0d fast=%0d",
                       v[49:38], v[37:26], v[25:14], v[13:2], v[1], v[0]);
   endfunction

   function automatic logic [49:0] obs_vec();
      return {x1, x2, y1, y2, moving, fast};
   endfunction

   task automatic model_reset();
      m_l = 0; m_r = 0; m_t = 0; m_b = 0;
      m_x = IX; m_y = IY; m_run = 0; m_pdx = 0; m_pdy = 0;
   endtask

   task automatic model_tick();
      int dx, dy, st;
      dx = axis(m_r, m_l);
      dy = axis(m_b, m_t);
      if (dx == 0 && dy == 0) begin
         m_run = 0;
      end else begin
         if (m_run > 0 && dx == m_pdx && dy == m_pdy) begin
            if (m_run < 1000) m_run++;
         end else begin
            m_run = 1;
         end
         m_pdx = dx;
         m_pdy = dy;
         st  = (m_run > HOLD) ? FSTEP : STEP;
         m_x = clampi(m_x + dx * st, H, DW - H);
         m_y = clampi(m_y + dy * st, H, DH - H);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bl = 0; br = 0; bt = 0; bb = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
   endtask

   // Buttons change, then settle past the sync+debounce latency.
   task automatic set_btn(input int l, input int r, input int t, input int b);
      @(negedge clk);
      bl = 1'(l); br = 1'(r); bt = 1'(t); bb = 1'(b);
      repeat (DB + 4) @(negedge clk);
      m_l = l; m_r = r; m_t = t; m_b = b;
   endtask

   task automatic do_tick();
      @(negedge clk);
      stb = 1'b1; anim = 1'b1;
      @(negedge clk);
      stb = 1'b0; anim = 1'b0;
      @(negedge clk);
      model_tick();
      tick_no++;
      $display("tick %0d: %s", tick_no, fmt(obs_vec()));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      check_cnt++;
      if ({x1, x2, y1, y2, moving, fast} !== {12'd100, 12'd220, 12'd60, 12'd180, 1'b0, 1'b0})
         $display("FAIL reset: got %s, expected x1=100 x2=220 y1=60 y2=180 moving=0 fast=0",
                  fmt(obs_vec()));
      else pass_cnt++;
   endtask

   task automatic test_accel();
      set_btn(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         do_tick();
         check_cnt++;
         if (obs_vec() !== exp_vec())
            $display("FAIL accel[%0d]: got %s, expected %s", i, fmt(obs_vec()), fmt(exp_vec()));
         else pass_cnt++;
      end
      check_cnt++;
      if (x1 !== 12'd111)
         $display("FAIL accel_x: got x1=%0d, expected 111", x1);
      else pass_cnt++;
      set_btn(0, 0, 0, 0);
      do_tick();
      check_cnt++;
      if (obs_vec() !== exp_vec())
         $display("FAIL release: got %s, expected %s", fmt(obs_vec()), fmt(exp_vec()));
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      do_reset();
      @(negedge clk); br = 1'b1;
      repeat (3) @(negedge clk);
      br = 1'b0;
      repeat (DB + 4) @(negedge clk);
      for (int i = 0; i < 10; i++) do_tick();
      check_cnt++;
      if (obs_vec() !== exp_vec() || x1 !== 12'd100)
         $display("FAIL glitch: got %s, expected %s", fmt(obs_vec()), fmt(exp_vec()));
      else pass_cnt++;
   endtask

   task automatic test_conflict();
      do_reset();
      set_btn(1, 1, 1, 0);
      for (int i = 0; i < 5; i++) begin
         do_tick();
         check_cnt++;
         if (obs_vec() !== exp_vec())
            $display("FAIL conflict[%0d]: got %s, expected %s", i, fmt(obs_vec()), fmt(exp_vec()));
         else pass_cnt++;
      end
   endtask

   task automatic test_clamp();
      do_reset();
      set_btn(1, 0, 0, 0);
      for (int i = 0; i < 50; i++) begin
         do_tick();
         check_cnt++;
         if (obs_vec() !== exp_vec())
            $display("FAIL clamp[%0d]: got %s, expected %s", i, fmt(obs_vec()), fmt(exp_vec()));
         else pass_cnt++;
      end
      check_cnt++;
      if (x1 !== 12'd0 || fast !== 1'b1)
         $display("FAIL clamp_edge: got x1=%0d fast=%0d, expected x1=0 fast=1", x1, fast);
      else pass_cnt++;
   endtask

   task automatic test_switch_and_reset();
      do_reset();
      set_btn(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) do_tick();
      set_btn(0, 0, 0, 1);
      do_tick();
      check_cnt++;
      if (obs_vec() !== exp_vec() || y1 !== 12'd61 || fast !== 1'b0)
         $display("FAIL switch: got %s, expected %s", fmt(obs_vec()), fmt(exp_vec()));
      else pass_cnt++;
      do_tick();
      @(negedge clk);
      rst = 1'b1; stb = 1'b1; anim = 1'b1;
      @(negedge clk);
      rst = 1'b0; stb = 1'b0; anim = 1'b0;
      @(negedge clk);
      model_reset();
      check_cnt++;
      if (obs_vec() !== exp_vec())
         $display("FAIL reset_on_tick: got %s, expected %s", fmt(obs_vec()), fmt(exp_vec()));
      else pass_cnt++;
      set_btn(0, 0, 0, 0);
   endtask

   task automatic test_random();
      int l, r, t, b, n;
      do_reset();
      l = 0; r = 0; t = 0; b = 0;
      for (int it = 0; it < 120; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            l = int'($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 1));
            t = int'($urandom_range(0, 2) == 0);
            b = int'($urandom_range(0, 1));
            set_btn(l, r, t, b);
         end
         if ($urandom_range(0, 3) == 0) begin
            // animate without the pixel strobe must not count as a tick
            @(negedge clk); anim = 1'b1;
            @(negedge clk); anim = 1'b0;
         end
         n = int'($urandom_range(1, 8));
         for (int k = 0; k < n; k++) begin
            do_tick();
            check_cnt++;
            if (obs_vec() !== exp_vec())
               $display("FAIL random[%0d.%0d]: got %s, expected %s", it, k,
                        fmt(obs_vec()), fmt(exp_vec()));
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_accel();
      test_glitch();
      test_conflict();
      test_clamp();
      test_switch_and_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
